// File: rtl/control_sequencer_pkg.sv
// Shared opcode, ALU-command and branch-condition constants plus the control word layout
// used by ctrl_decode and control_sequencer.
package control_sequencer_pkg;

  localparam logic [5:0] OP_NOP  = 6'd0;
  localparam logic [5:0] OP_ADD  = 6'd1;
  localparam logic [5:0] OP_SUB  = 6'd2;
  localparam logic [5:0] OP_AND  = 6'd3;
  localparam logic [5:0] OP_OR   = 6'd4;
  localparam logic [5:0] OP_NOR  = 6'd5;
  localparam logic [5:0] OP_XOR  = 6'd6;
  localparam logic [5:0] OP_SLA  = 6'd7;
  localparam logic [5:0] OP_SLL  = 6'd8;
  localparam logic [5:0] OP_SRA  = 6'd9;
  localparam logic [5:0] OP_SRL  = 6'd10;
  localparam logic [5:0] OP_MUL  = 6'd16;
  localparam logic [5:0] OP_ADDI = 6'd32;
  localparam logic [5:0] OP_SUBI = 6'd33;
  localparam logic [5:0] OP_LD   = 6'd36;
  localparam logic [5:0] OP_ST   = 6'd37;
  localparam logic [5:0] OP_BEZ  = 6'd40;
  localparam logic [5:0] OP_BNE  = 6'd41;
  localparam logic [5:0] OP_JMP  = 6'd42;

  // R-type ALU commands share the low opcode bits, so EXE_CMD is the opcode itself.
  localparam logic [3:0] EXE_ADD          = 4'd1;
  localparam logic [3:0] EXE_SUB          = 4'd2;
  localparam logic [3:0] EXE_MUL          = 4'd11;
  localparam logic [3:0] EXE_NO_OPERATION = 4'd15;

  localparam logic [1:0] COND_NONE = 2'd0;
  localparam logic [1:0] COND_BEZ  = 2'd1;
  localparam logic [1:0] COND_BNE  = 2'd2;
  localparam logic [1:0] COND_JUMP = 2'd3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MULT = 1'b1
  } state_t;

  typedef struct packed {
    logic [3:0] exe_cmd;
    logic [1:0] branch_cmd;
    logic       branch_en;
    logic       is_imm;
    logic       st_or_bne;
    logic       wb_en;
    logic       mem_r_en;
    logic       mem_w_en;
  } ctrl_word_t;

  localparam ctrl_word_t CTRL_BUBBLE = ctrl_word_t'(12'h000);

  localparam ctrl_word_t CTRL_MUL = '{exe_cmd: EXE_MUL, branch_cmd: COND_NONE,
                                      branch_en: 1'b0, is_imm: 1'b0, st_or_bne: 1'b0,
                                      wb_en: 1'b1, mem_r_en: 1'b0, mem_w_en: 1'b0};

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder: operation -> control word plus an undefined-opcode flag.
// OP_MUL is only a legal opcode when MULDIV_SUPPORT_EN is defined.
module ctrl_decode
  import control_sequencer_pkg::*;
#(
  parameter int OP_WIDTH = 6
) (
  input  logic [OP_WIDTH-1:0] operation,
  output ctrl_word_t          word,
  output logic                illegal
);

  logic [5:0] op_s;
  assign op_s = 6'(operation);

  // Opcode table; MUL decodes to a bubble here because its result word comes from the sequencer.
  always_comb begin
    word    = CTRL_BUBBLE;
    illegal = 1'b0;
    case (op_s)
      OP_NOP: begin
        word = CTRL_BUBBLE;
      end
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOR, OP_XOR, OP_SLA, OP_SLL, OP_SRA, OP_SRL: begin
        word.exe_cmd = op_s[3:0];
        word.wb_en   = 1'b1;
      end
      OP_ADDI: begin
        word.exe_cmd = EXE_ADD;
        word.wb_en   = 1'b1;
        word.is_imm  = 1'b1;
      end
      OP_SUBI: begin
        word.exe_cmd = EXE_SUB;
        word.wb_en   = 1'b1;
        word.is_imm  = 1'b1;
      end
      OP_LD: begin
        word.exe_cmd   = EXE_ADD;
        word.wb_en     = 1'b1;
        word.is_imm    = 1'b1;
        word.st_or_bne = 1'b1;
        word.mem_r_en  = 1'b1;
      end
      OP_ST: begin
        word.exe_cmd   = EXE_ADD;
        word.is_imm    = 1'b1;
        word.st_or_bne = 1'b1;
        word.mem_w_en  = 1'b1;
      end
      OP_BEZ: begin
        word.exe_cmd    = EXE_NO_OPERATION;
        word.is_imm     = 1'b1;
        word.branch_en  = 1'b1;
        word.branch_cmd = COND_BEZ;
      end
      OP_BNE: begin
        word.exe_cmd    = EXE_NO_OPERATION;
        word.is_imm     = 1'b1;
        word.branch_en  = 1'b1;
        word.branch_cmd = COND_BNE;
        word.st_or_bne  = 1'b1;
      end
      OP_JMP: begin
        word.exe_cmd    = EXE_NO_OPERATION;
        word.is_imm     = 1'b1;
        word.branch_en  = 1'b1;
        word.branch_cmd = COND_JUMP;
      end
`ifdef MULDIV_SUPPORT_EN
      OP_MUL: begin
        word = CTRL_BUBBLE;
      end
`endif
      default: begin
        word    = CTRL_BUBBLE;
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// ID-stage control sequencer: registers the decoded control word at the ID/EXE boundary.
// Define MULDIV_SUPPORT_EN to compile in the multi-cycle MUL path (MULT state, counter, OP_MUL).
module control_sequencer
  import control_sequencer_pkg::*;
#(
  parameter int OP_WIDTH      = 6,
  parameter int EXE_CMD_WIDTH = 4,
  parameter int MUL_LAT       = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [OP_WIDTH-1:0]      operation,
  input  logic                     instr_valid,
  input  logic                     hazard_detected,
  input  logic                     flush,
  output logic [EXE_CMD_WIDTH-1:0] EXE_CMD,
  output logic [1:0]               Branch_command,
  output logic                     branchEn,
  output logic                     Is_Imm,
  output logic                     ST_or_BNE,
  output logic                     WB_EN,
  output logic                     MEM_R_EN,
  output logic                     MEM_W_EN,
  output logic                     freeze,
  output logic                     busy,
  output logic                     illegal_op
);

  if (MUL_LAT < 2 || MUL_LAT > 15) begin : g_mul_lat_range
    $error("control_sequencer: MUL_LAT must lie in 2..15");
  end

  ctrl_word_t dec_word_s;
  logic       dec_illegal_s;
  logic       accept_s;
  ctrl_word_t nxt_word_s;
  logic       nxt_ill_s;
  ctrl_word_t word_r;
  logic       illegal_r;

  ctrl_decode #(.OP_WIDTH(OP_WIDTH)) u_decode (
    .operation (operation),
    .word      (dec_word_s),
    .illegal   (dec_illegal_s)
  );

  assign accept_s = instr_valid & ~flush & ~hazard_detected;

`ifdef MULDIV_SUPPORT_EN
  localparam int CNT_W = $clog2(MUL_LAT);

  state_t           state_r;
  state_t           nxt_state_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] nxt_cnt_s;
  logic             freeze_s;
  logic             is_mul_s;

  assign is_mul_s = (6'(operation) == OP_MUL);

  // Next-word selection and MUL sequencing; operation is ignored while in MULT (IF/ID is frozen).
  always_comb begin
    nxt_word_s  = CTRL_BUBBLE;
    nxt_ill_s   = 1'b0;
    nxt_state_s = state_r;
    nxt_cnt_s   = cnt_r;
    freeze_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!accept_s) begin
          nxt_word_s = CTRL_BUBBLE;
        end else if (dec_illegal_s) begin
          nxt_ill_s = 1'b1;
        end else if (is_mul_s) begin
          nxt_state_s = ST_MULT;
          nxt_cnt_s   = CNT_W'(MUL_LAT - 1);
          freeze_s    = 1'b1;
        end else begin
          nxt_word_s = dec_word_s;
        end
      end
      ST_MULT: begin
        if (flush) begin
          nxt_state_s = ST_IDLE;
          nxt_cnt_s   = CNT_W'(0);
        end else if (cnt_r <= CNT_W'(1)) begin
          nxt_word_s  = CTRL_MUL;
          nxt_state_s = ST_IDLE;
          nxt_cnt_s   = CNT_W'(0);
        end else begin
          nxt_cnt_s = cnt_r - CNT_W'(1);
          freeze_s  = 1'b1;
        end
      end
      default: begin
        nxt_state_s = ST_IDLE;
        nxt_cnt_s   = CNT_W'(0);
      end
    endcase
  end

  // FSM state, MUL counter and the ID/EXE control register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      cnt_r     <= CNT_W'(0);
      word_r    <= CTRL_BUBBLE;
      illegal_r <= 1'b0;
    end else begin
      state_r   <= nxt_state_s;
      cnt_r     <= nxt_cnt_s;
      word_r    <= nxt_word_s;
      illegal_r <= nxt_ill_s;
    end
  end

  assign freeze = freeze_s & ~rst;
  assign busy   = (state_r == ST_MULT);
`else
  // Single-cycle decode path: bubble unless an instruction is accepted.
  always_comb begin
    nxt_word_s = CTRL_BUBBLE;
    nxt_ill_s  = 1'b0;
    if (!accept_s) begin
      nxt_word_s = CTRL_BUBBLE;
    end else if (dec_illegal_s) begin
      nxt_ill_s = 1'b1;
    end else begin
      nxt_word_s = dec_word_s;
    end
  end

  // ID/EXE control register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_r    <= CTRL_BUBBLE;
      illegal_r <= 1'b0;
    end else begin
      word_r    <= nxt_word_s;
      illegal_r <= nxt_ill_s;
    end
  end

  assign freeze = 1'b0;
  assign busy   = 1'b0;
`endif

  assign EXE_CMD        = EXE_CMD_WIDTH'(word_r.exe_cmd);
  assign Branch_command = word_r.branch_cmd;
  assign branchEn       = word_r.branch_en;
  assign Is_Imm         = word_r.is_imm;
  assign ST_or_BNE      = word_r.st_or_bne;
  assign WB_EN          = word_r.wb_en;
  assign MEM_R_EN       = word_r.mem_r_en;
  assign MEM_W_EN       = word_r.mem_w_en;
  assign illegal_op     = illegal_r;

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: directed scenarios with literal expectations,
// then randomized stimulus compared every cycle against a behavioural model.
`timescale 1ns/1ps
module tb_control_sequencer;

  localparam int MUL_LAT = 4;
`ifdef MULDIV_SUPPORT_EN
  localparam bit MULDIV = 1'b1;
`else
  localparam bit MULDIV = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] operation;
  logic       instr_valid;
  logic       hazard_detected;
  logic       flush;
  logic [3:0] EXE_CMD;
  logic [1:0] Branch_command;
  logic       branchEn, Is_Imm, ST_or_BNE, WB_EN, MEM_R_EN, MEM_W_EN;
  logic       freeze, busy, illegal_op;

  always #5 clk = ~clk;

  control_sequencer #(.OP_WIDTH(6), .EXE_CMD_WIDTH(4), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .rst(rst), .operation(operation), .instr_valid(instr_valid),
    .hazard_detected(hazard_detected), .flush(flush), .EXE_CMD(EXE_CMD),
    .Branch_command(Branch_command), .branchEn(branchEn), .Is_Imm(Is_Imm),
    .ST_or_BNE(ST_or_BNE), .WB_EN(WB_EN), .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN),
    .freeze(freeze), .busy(busy), .illegal_op(illegal_op)
  );

  // Word layout: {EXE_CMD, Branch_command, branchEn, Is_Imm, ST_or_BNE, WB_EN, MEM_R_EN, MEM_W_EN}
  wire [11:0] got_word = {EXE_CMD, Branch_command, branchEn, Is_Imm, ST_or_BNE,
                          WB_EN, MEM_R_EN, MEM_W_EN};

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got=%h expected=%h", name, $time, got, exp);
    end
  endtask

  function automatic bit is_legal(input logic [5:0] op);
    return (op <= 6'd10) || (op inside {6'd32, 6'd33, 6'd36, 6'd37, 6'd40, 6'd41, 6'd42}) ||
           (MULDIV && op == 6'd16);
  endfunction

  function automatic logic [11:0] ref_word(input logic [5:0] op);
    case (op)
      6'd0:    return 12'h000;
      6'd32:   return 12'h114;
      6'd33:   return 12'h214;
      6'd36:   return 12'h11E;
      6'd37:   return 12'h119;
      6'd40:   return 12'hF70;
      6'd41:   return 12'hFB8;
      6'd42:   return 12'hFF0;
      default: return (op <= 6'd10) ? {op[3:0], 8'h04} : 12'h000;
    endcase
  endfunction

  // Model state: expected registered word/pulse and cycles elapsed since a MUL was accepted.
  logic [11:0] m_word = 12'h000;
  logic        m_ill  = 1'b0;
  int          m_age  = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_word <= 12'h000;
      m_ill  <= 1'b0;
      m_age  <= 0;
    end else if (m_age != 0) begin
      m_ill <= 1'b0;
      if (flush) begin
        m_word <= 12'h000;
        m_age  <= 0;
      end else if (m_age == MUL_LAT - 1) begin
        m_word <= 12'hB04;
        m_age  <= 0;
      end else begin
        m_word <= 12'h000;
        m_age  <= m_age + 1;
      end
    end else begin
      m_word <= 12'h000;
      m_ill  <= 1'b0;
      m_age  <= 0;
      if (instr_valid && !flush && !hazard_detected) begin
        if (MULDIV && operation == 6'd16) m_age <= 1;
        else if (!is_legal(operation))    m_ill <= 1'b1;
        else                              m_word <= ref_word(operation);
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      logic exp_freeze;
      if (rst)              exp_freeze = 1'b0;
      else if (m_age == 0)  exp_freeze = MULDIV && instr_valid && !flush && !hazard_detected &&
                                         operation == 6'd16;
      else                  exp_freeze = !flush && (m_age < MUL_LAT - 1);
      chk("model_word", got_word, m_word);
      chk("model_illegal_op", illegal_op, m_ill);
      chk("model_busy", busy, m_age != 0);
      chk("model_freeze", freeze, exp_freeze);
    end
  end

  task automatic drive(input logic [5:0] op, input bit v, input bit h, input bit f);
    operation       = op;
    instr_valid     = v;
    hazard_detected = h;
    flush           = f;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [5:0] legal_ops [18] = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7, 6'd8,
                                 6'd9, 6'd10, 6'd32, 6'd33, 6'd36, 6'd37, 6'd40, 6'd41, 6'd42};

  initial begin
    rst = 1'b1;
    drive(6'd0, 1'b0, 1'b0, 1'b0);
    #1 chk_en = 1'b1;
    tick();
    chk("rst_word", got_word, 12'h000);
    chk("rst_busy_freeze", {busy, freeze, illegal_op}, 3'b000);
    rst = 1'b0;
    tick();

    drive(6'd32, 1'b1, 1'b0, 1'b0);
    tick();
    chk("addi_word", got_word, 12'h114);

    drive(6'd36, 1'b1, 1'b1, 1'b0);
    tick();
    chk("ld_hazard_bubble", got_word, 12'h000);
    drive(6'd36, 1'b1, 1'b0, 1'b0);
    tick();
    chk("ld_word", got_word, 12'h11E);

    drive(6'h3F, 1'b1, 1'b0, 1'b0);
    tick();
    chk("illegal_pulse", {illegal_op, got_word}, {1'b1, 12'h000});
    drive(6'h3F, 1'b0, 1'b0, 1'b0);
    tick();
    chk("illegal_pulse_end", illegal_op, 1'b0);
    tick();
    chk("illegal_invalid_none", illegal_op, 1'b0);

    // MUL: freeze 1,1,1,0 and busy 0,1,1,1 over the four cycles, MUL word on the 4th edge.
    drive(6'd16, 1'b1, 1'b0, 1'b0);
    #1;
`ifdef MULDIV_SUPPORT_EN
    for (int k = 0; k < 4; k++) begin
      chk("mul_freeze", freeze, (k < 3));
      chk("mul_busy", busy, (k > 0));
      tick();
      chk("mul_word", got_word, (k == 3) ? 12'hB04 : 12'h000);
    end
    chk("mul_busy_done", busy, 1'b0);
    drive(6'd0, 1'b0, 1'b0, 1'b0);
    tick();

    // Flush on the second MULT cycle aborts the op.
    drive(6'd16, 1'b1, 1'b0, 1'b0);
    tick();
    tick();
    drive(6'd16, 1'b1, 1'b0, 1'b1);
    #1;
    chk("flush_freeze_low", {busy, freeze}, 2'b10);
    tick();
    chk("flush_bubble", {busy, got_word}, 13'h0000);
    drive(6'd0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("flush_no_mul", (got_word == 12'hB04), 1'b0);
    end
`else
    chk("nomul_freeze", freeze, 1'b0);
    tick();
    chk("nomul_illegal", {illegal_op, busy, freeze, got_word}, {3'b100, 12'h000});
    drive(6'd0, 1'b0, 1'b0, 1'b0);
    tick();
`endif

    // Reset in the middle of a MUL, then a BNE must decode normally.
    drive(6'd16, 1'b1, 1'b0, 1'b0);
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("midrst_outputs", {busy, freeze, illegal_op, got_word}, 15'h0000);
    tick();
    rst = 1'b0;
    drive(6'd0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("post_rst_quiet", {busy, got_word}, 13'h0000);
    drive(6'd41, 1'b1, 1'b0, 1'b0);
    tick();
    chk("bne_word", got_word, 12'hFB8);

    for (int i = 0; i < 800; i++) begin
      int r;
      logic [5:0] op;
      r = $urandom_range(0, 99);
      if (r < 25)      op = 6'd16;
      else if (r < 35) op = 6'($urandom_range(0, 63));
      else             op = legal_ops[$urandom_range(0, 17)];
      drive(op, ($urandom_range(0, 99) < 85), ($urandom_range(0, 99) < 12),
            ($urandom_range(0, 99) < 6));
      tick();
    end

    drive(6'd0, 1'b0, 1'b0, 1'b0);
    repeat (MUL_LAT + 2) tick();
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
